// File: rtl/sr_latch_bank_pkg.sv
// Shared types and constants for the clocked SR latch bank.
package sr_latch_bank_pkg;

  typedef enum logic [1:0] {
    SR_SET_DOM = 2'd0,
    SR_RST_DOM = 2'd1,
    SR_HOLD    = 2'd2,
    SR_TOGGLE  = 2'd3
  } sr_mode_e;

  localparam int unsigned CONFLICT_CNT_W = 8;

  function automatic logic [CONFLICT_CNT_W-1:0] sat_inc(input logic [CONFLICT_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sr_latch_bank_cell.sv
// sr_cell: one SR channel -- input normalisation, optional rising-edge
// qualification, conflict-policy next state and sticky conflict flag.
module sr_cell
  import sr_latch_bank_pkg::*;
#(
  parameter sr_mode_e MODE          = SR_SET_DOM,
  parameter bit       ACTIVE_LOW_IN = 1'b1,
  parameter bit       EDGE_MODE     = 1'b0,
  parameter logic     RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic reset_i,
  input  logic clr_conflict,
  output logic q,
  output logic conflict,
  output logic hit
);

  logic s, r, s_eff, r_eff, q_nxt;

  assign s = ACTIVE_LOW_IN ? ~set_i : set_i;
  assign r = ACTIVE_LOW_IN ? ~reset_i : reset_i;

  if (EDGE_MODE) begin : g_edge
    logic s_q, r_q;
    // History resets inactive, so a request held through rst fires once.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q <= 1'b0;
        r_q <= 1'b0;
      end else begin
        s_q <= s;
        r_q <= r;
      end
    end
    assign s_eff = s & ~s_q;
    assign r_eff = r & ~r_q;
  end else begin : g_level
    assign s_eff = s;
    assign r_eff = r;
  end

  assign hit = s_eff & r_eff;

  always_comb begin
    q_nxt = q;
    case ({s_eff, r_eff})
      2'b10: q_nxt = 1'b1;
      2'b01: q_nxt = 1'b0;
      2'b11: begin
        case (MODE)
          SR_SET_DOM: q_nxt = 1'b1;
          SR_RST_DOM: q_nxt = 1'b0;
          SR_HOLD:    q_nxt = q;
          SR_TOGGLE:  q_nxt = ~q;
        endcase
      end
      default: q_nxt = q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= RESET_VAL;
      conflict <= 1'b0;
    end else begin
      q        <= q_nxt;
      conflict <= hit | (conflict & ~clr_conflict);
    end
  end

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of WIDTH clocked SR channels replacing the cross-coupled NAND latch.
// Optional saturating conflict-cycle counter: SR_LATCH_BANK_CONFLICT_CNT_EN.
module sr_latch_bank
  import sr_latch_bank_pkg::*;
#(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      MODE          = 0,
  parameter bit               ACTIVE_LOW_IN = 1'b1,
  parameter bit               EDGE_MODE     = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] set_i,
  input  logic [WIDTH-1:0] reset_i,
  input  logic             clr_conflict,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] conflict
`ifdef SR_LATCH_BANK_CONFLICT_CNT_EN
  ,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
`endif
);

  if (MODE > 3) begin : g_bad_mode
    $fatal(1, "sr_latch_bank: MODE must be 0..3");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "sr_latch_bank: WIDTH must be 1..64");
  end

  localparam sr_mode_e MODE_E = sr_mode_e'(MODE[1:0]);

  logic [WIDTH-1:0] hit;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .MODE          (MODE_E),
      .ACTIVE_LOW_IN (ACTIVE_LOW_IN),
      .EDGE_MODE     (EDGE_MODE),
      .RESET_VAL     (RESET_VAL[i])
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .set_i        (set_i[i]),
      .reset_i      (reset_i[i]),
      .clr_conflict (clr_conflict),
      .q            (q[i]),
      .conflict     (conflict[i]),
      .hit          (hit[i])
    );
  end

  assign qb = ~q;

`ifdef SR_LATCH_BANK_CONFLICT_CNT_EN
  logic hit_any;
  assign hit_any = |hit;

  // A conflict cycle coinciding with the clear restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (clr_conflict) begin
      conflict_cnt <= hit_any ? CONFLICT_CNT_W'(1) : '0;
    end else if (hit_any) begin
      conflict_cnt <= sat_inc(conflict_cnt);
    end
  end
`else
  logic unused_hit;
  assign unused_hit = ^hit;
`endif

endmodule
